descrambler: RTL and testbench

Receive-side 64b/66b PCS descrambler: the counterpart of the transmit scrambler. It accepts 66-bit blocks (2-bit sync header plus 64-bit scrambled payload) from the block-sync/gearbox stage and removes the self-synchronizing x^58+x^39+1 scrambling. It forwards the header untouched and emits descrambled blocks through a one-deep registered valid/ready stage toward the lane decoder. It also flags blocks produced before the history is primed, and counts invalid sync headers.

---
 rtl/descrambler.sv | 114 +++++++++++
 tb/tb_descrambler.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/descrambler.sv
// 64b/66b receive descrambler (x^58+x^39+1) with a one-deep output stage.
// Optional pass-through control enabled with DESCRAMBLER_BYPASS_EN.
module descrambler #(
   parameter int HDR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           in_header,
   input  logic [63:0]          in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [1:0]           out_header,
   output logic [63:0]          out_data,
   output logic                 out_primed,
   input  logic                 resync,
`ifdef DESCRAMBLER_BYPASS_EN
   input  logic                 bypass,
`endif
   output logic [HDR_CNT_W-1:0] hdr_err_cnt
);

   logic [57:0]          s_q, s_d;
   logic                 primed_q, primed_d;
   logic                 vld_q, vld_d;
   logic [1:0]           hdr_q, hdr_d;
   logic [63:0]          data_q, data_d;
   logic                 opr_q, opr_d;
   logic [HDR_CNT_W-1:0] cnt_q, cnt_d;

   logic [121:0] ext;
   logic [63:0]  desc;
   logic         accept;
   logic         take;
   logic         bad_hdr;
   logic         byp;

`ifdef DESCRAMBLER_BYPASS_EN
   assign byp = bypass;
`else
   assign byp = 1'b0;
`endif

   assign ext = {in_data, s_q};

   // Each output bit cancels the taps 39 and 58 bits back in the stream.
   always_comb begin
      desc = '0;
      for (int i = 0; i < 64; i++) begin
         desc[i] = ext[i+58] ^ ext[i+19] ^ ext[i];
      end
   end

   assign in_ready = !vld_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign take     = vld_q && out_ready;
   assign bad_hdr  = (in_header == 2'b00) || (in_header == 2'b11);

   always_comb begin
      s_d      = s_q;
      primed_d = primed_q;
      vld_d    = vld_q;
      hdr_d    = hdr_q;
      data_d   = data_q;
      opr_d    = opr_q;
      cnt_d    = cnt_q;
      if (resync) begin
         s_d      = '0;
         primed_d = 1'b0;
         cnt_d    = '0;
         vld_d    = 1'b0;
      end else if (accept) begin
         s_d      = in_data[63:6];
         hdr_d    = in_header;
         data_d   = byp ? in_data : desc;
         opr_d    = primed_q;
         primed_d = 1'b1;
         vld_d    = 1'b1;
         if (bad_hdr && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (take) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_q      <= '0;
         primed_q <= 1'b0;
         vld_q    <= 1'b0;
         hdr_q    <= '0;
         data_q   <= '0;
         opr_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         s_q      <= s_d;
         primed_q <= primed_d;
         vld_q    <= vld_d;
         hdr_q    <= hdr_d;
         data_q   <= data_d;
         opr_q    <= opr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_valid   = vld_q;
   assign out_header  = hdr_q;
   assign out_data    = data_q;
   assign out_primed  = opr_q;
   assign hdr_err_cnt = cnt_q;

endmodule

// File: tb/tb_descrambler.sv
// Self-checking bench for descrambler using bit-serial
// scrambler/descrambler reference models.
module tb_descrambler;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_header;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_header;
   logic [63:0] out_data;
   logic        out_primed;
   logic        resync;
   logic        bypass;
   logic [7:0]  hdr_err_cnt;

   int checks = 0;
   int failures = 0;

   bit rxh[$];
   bit txh[$];

   descrambler #(.HDR_CNT_W(8)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_header(in_header),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_header(out_header),
      .out_data(out_data),
      .out_primed(out_primed),
      .resync(resync),
`ifdef DESCRAMBLER_BYPASS_EN
      .bypass(bypass),
`endif
      .hdr_err_cnt(hdr_err_cnt)
   );

   always #5 clk = ~clk;

   // Receiver model: serial stream, each bit xor'd with bits 39 and 58 back.
   task automatic model_reset();
      rxh.delete();
      repeat (58) rxh.push_back(1'b0);
   endtask

   task automatic model_rx(input logic [63:0] d, output logic [63:0] o);
      o = '0;
      for (int i = 0; i < 64; i++) begin
         o[i] = d[i] ^ rxh[rxh.size()-39] ^ rxh[rxh.size()-58];
         rxh.push_back(d[i]);
         void'(rxh.pop_front());
      end
   endtask

   task automatic tx_seed();
      txh.delete();
      for (int i = 0; i < 58; i++) txh.push_back(bit'($urandom_range(0, 1)));
   endtask

   task automatic model_tx(input logic [63:0] d, output logic [63:0] o);
      o = '0;
      for (int i = 0; i < 64; i++) begin
         o[i] = d[i] ^ txh[txh.size()-39] ^ txh[txh.size()-58];
         txh.push_back(o[i]);
         void'(txh.pop_front());
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      in_header = 2'b00;
      in_data = '0;
      resync = 1'b0;
      out_ready = 1'b1;
      bypass = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic send_block(input logic [1:0] h, input logic [63:0] d,
                             input logic byp);
      @(negedge clk);
      in_valid = 1'b1;
      in_header = h;
      in_data = d;
      out_ready = 1'b1;
      bypass = byp;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      bypass = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 64'h0 || out_header !== 2'b00 ||
          out_primed !== 1'b0 || hdr_err_cnt !== 8'h00 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset: v=%b d=%h h=%b p=%b cnt=%h rdy=%b, want all 0, rdy 1",
                  out_valid, out_data, out_header, out_primed, hdr_err_cnt, in_ready);
      end
   endtask

   task automatic test_vector();
      do_reset();
      send_block(2'b01, 64'h0000_0000_0000_0001, 1'b0);
      checks++;
      if (out_data !== 64'h0400_0080_0000_0001) begin
         failures++;
         $display("FAIL vector_data: got %h want 0400008000000001", out_data);
      end
      checks++;
      if (out_header !== 2'b01 || out_primed !== 1'b0 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL vector_flags: h=%b p=%b v=%b want 01 0 1",
                  out_header, out_primed, out_valid);
      end
   endtask

   task automatic test_loopback();
      logic [63:0] d, scr, e;
      logic [1:0] h;
      do_reset();
      tx_seed();
      for (int n = 0; n < 1000; n++) begin
         d = {$urandom, $urandom};
         h = 2'($urandom_range(1, 2));
         model_tx(d, scr);
         send_block(h, scr, 1'b0);
         model_rx(scr, e);
         checks++;
         if (out_data !== e || out_header !== h) begin
            failures++;
            $display("FAIL loop_model n=%0d: got %h/%b want %h/%b",
                     n, out_data, out_header, e, h);
         end
         checks++;
         if (out_primed !== (n != 0)) begin
            failures++;
            $display("FAIL loop_primed n=%0d: got %b want %b", n, out_primed, n != 0);
         end
         if (n >= 1) begin
            checks++;
            if (out_data !== d) begin
               failures++;
               $display("FAIL loop_plain n=%0d: got %h want %h", n, out_data, d);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] blk[20];
      logic [63:0] expq[$];
      logic [63:0] e, prev;
      logic [1:0] prevh;
      logic acc, tk, stall;
      int idx, got, cyc;
      do_reset();
      for (int i = 0; i < 20; i++) blk[i] = {$urandom, $urandom};
      idx = 0;
      got = 0;
      cyc = 0;
      prev = '0;
      prevh = '0;
      while (got < 20 && cyc < 200) begin
         @(negedge clk);
         stall = (cyc >= 6 && cyc < 11);
         in_valid = (idx < 20);
         in_header = 2'b10;
         in_data = (idx < 20) ? blk[idx] : 64'h0;
         out_ready = !stall;
         #1;
         if (stall && cyc > 6) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                out_data !== prev || out_header !== prevh) begin
               failures++;
               $display("FAIL bp_stall cyc=%0d: rdy=%b v=%b d=%h want rdy 0 v 1 d %h",
                        cyc, in_ready, out_valid, out_data, prev);
            end
         end
         acc = in_valid && in_ready;
         tk = out_valid && out_ready;
         if (tk) begin
            checks++;
            if (expq.size() == 0) begin
               failures++;
               $display("FAIL bp_dup: got %h want no block", out_data);
            end else begin
               e = expq.pop_front();
               if (out_data !== e) begin
                  failures++;
                  $display("FAIL bp_data #%0d: got %h want %h", got, out_data, e);
               end
            end
            got++;
         end
         prev = out_data;
         prevh = out_header;
         @(posedge clk);
         if (acc) begin
            model_rx(blk[idx], e);
            expq.push_back(e);
            idx++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (got !== 20 || expq.size() !== 0) begin
         failures++;
         $display("FAIL bp_count: got %0d left %0d want 20 0", got, expq.size());
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_drain: out_valid %b want 0", out_valid);
      end
   endtask

   task automatic test_hdr_err();
      do_reset();
      send_block(2'b00, {$urandom, $urandom}, 1'b0);
      send_block(2'b11, {$urandom, $urandom}, 1'b0);
      send_block(2'b10, {$urandom, $urandom}, 1'b0);
      send_block(2'b00, {$urandom, $urandom}, 1'b0);
      checks++;
      if (hdr_err_cnt !== 8'd3) begin
         failures++;
         $display("FAIL hdr_cnt3: got %0d want 3", hdr_err_cnt);
      end
      for (int i = 0; i < 300; i++) begin
         send_block((i % 2) ? 2'b11 : 2'b00, {$urandom, $urandom}, 1'b0);
         if (i == 250) begin
            checks++;
            if (hdr_err_cnt !== 8'd254) begin
               failures++;
               $display("FAIL hdr_cnt254: got %0d want 254", hdr_err_cnt);
            end
         end
      end
      checks++;
      if (hdr_err_cnt !== 8'hFF) begin
         failures++;
         $display("FAIL hdr_sat: got %h want ff", hdr_err_cnt);
      end
   endtask

   task automatic test_resync();
      logic [63:0] d, e;
      do_reset();
      send_block(2'b11, {$urandom, $urandom}, 1'b0);
      send_block(2'b01, {$urandom, $urandom}, 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      in_header = 2'b00;
      in_data = {$urandom, $urandom};
      resync = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      resync = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || hdr_err_cnt !== 8'h00) begin
         failures++;
         $display("FAIL resync_clear: v=%b cnt=%0d want 0 0", out_valid, hdr_err_cnt);
      end
      model_reset();
      d = {$urandom, $urandom};
      send_block(2'b01, d, 1'b0);
      model_rx(d, e);
      checks++;
      if (out_primed !== 1'b0 || out_data !== e || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL resync_next: p=%b d=%h v=%b want 0 %h 1",
                  out_primed, out_data, out_valid, e);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      send_block(2'b00, 64'hDEAD_BEEF_0123_4567, 1'b0);
      send_block(2'b01, 64'hFFFF_0000_FFFF_0000, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 64'h0 || out_header !== 2'b00 ||
          out_primed !== 1'b0 || hdr_err_cnt !== 8'h00) begin
         failures++;
         $display("FAIL async_reset: v=%b d=%h h=%b p=%b cnt=%0d want all 0",
                  out_valid, out_data, out_header, out_primed, hdr_err_cnt);
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

`ifdef DESCRAMBLER_BYPASS_EN
   task automatic test_bypass();
      logic [63:0] a, b, e;
      do_reset();
      a = {$urandom, $urandom} | 64'h1;
      b = {$urandom, $urandom};
      send_block(2'b01, a, 1'b1);
      model_rx(a, e);
      checks++;
      if (out_data !== a) begin
         failures++;
         $display("FAIL bypass_raw: got %h want %h", out_data, a);
      end
      send_block(2'b10, b, 1'b0);
      model_rx(b, e);
      checks++;
      if (out_data !== e || out_primed !== 1'b1) begin
         failures++;
         $display("FAIL bypass_next: got %h p=%b want %h p=1", out_data, out_primed, e);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_vector();
      test_loopback();
      test_backpressure();
      test_hdr_err();
      test_resync();
      test_async_reset();
`ifdef DESCRAMBLER_BYPASS_EN
      test_bypass();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
